// File: rtl/approx_pkg.sv
// Shared definitions for the approximate-adder arbiter: default sizes,
// FSM state encoding and error-monitor accumulator widths.
package approx_pkg;

   localparam int DEF_NREQ  = 4;
   localparam int DEF_WIDTH = 32;

   // Error-monitor accumulator widths (used when ERR_MONITOR_EN is defined)
   localparam int SAE_W = 48;
   localparam int CNT_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first requester at or after (i_last+1) mod NREQ,
// searching upward with wrap. Purely combinational; o_gnt is zero and
// o_any low when no request is present.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDW-1:0]  i_last,
   output logic [NREQ-1:0] o_gnt,
   output logic [IDW-1:0]  o_idx,
   output logic            o_any
);

   // Scan offsets from farthest to nearest so the nearest match wins
   always_comb begin
      logic [IDW-1:0] cand;
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      cand  = '0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = IDW'((int'(i_last) + k) % NREQ);
         if (i_req[cand]) begin
            o_gnt       = '0;
            o_gnt[cand] = 1'b1;
            o_idx       = cand;
            o_any       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/approx_add_arbiter.sv
// Round-robin sequencer sharing one external combinational approximate
// adder among NREQ requesters. Operands are latched on a request
// handshake, held on adder_a/adder_b for SETTLE_CYC cycles, then the
// adder result is returned with the requester id.
// Optional error monitor: define ERR_MONITOR_EN to add err_clr/err_cnt/
// err_sae/err_max_ae, comparing each captured sum against the exact sum.
//
// Handshakes: a transfer happens on a rising Clk edge where valid and
// ready are both high. req_ready is one-hot (or zero), asserted only in
// IDLE; rsp_valid/rsp_id/rsp_sum hold steady until rsp_ready is seen.
module approx_add_arbiter
   import approx_pkg::*;
#(
   parameter int NREQ       = DEF_NREQ,
   parameter int WIDTH      = DEF_WIDTH,
   parameter int SETTLE_CYC = 1,
   parameter int IDW        = $clog2(NREQ)
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [WIDTH-1:0]      adder_a,
   output logic [WIDTH-1:0]      adder_b,
   input  logic [WIDTH:0]        adder_sum,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH:0]        rsp_sum,
`ifdef ERR_MONITOR_EN
   input  logic                  err_clr,
   output logic [CNT_W-1:0]      err_cnt,
   output logic [SAE_W-1:0]      err_sae,
   output logic [WIDTH:0]        err_max_ae,
`endif
   output state_t                dbg_state
);

   localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYC - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [3:0]       r_cnt;
   logic [IDW-1:0]   r_id;
   logic [IDW-1:0]   r_last;

   logic [NREQ-1:0]  w_gnt;
   logic [IDW-1:0]   w_idx;
   logic             w_any;

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .i_req  (req_valid),
      .i_last (r_last),
      .o_gnt  (w_gnt),
      .o_idx  (w_idx),
      .o_any  (w_any)
   );

   // Offer the pick only when idle and out of reset; a handshake is then w_any
   assign req_ready = (r_state == IDLE && !Rst) ? w_gnt : '0;
   assign adder_a   = r_a;
   assign adder_b   = r_b;
   assign dbg_state = r_state;

   // Main sequencer: grant, hold operands for the settle time, return result
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state   <= IDLE;
         r_a       <= '0;
         r_b       <= '0;
         r_cnt     <= '0;
         r_id      <= '0;
         r_last    <= IDW'(NREQ - 1);
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_sum   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_a     <= req_a[int'(w_idx)*WIDTH +: WIDTH];
                  r_b     <= req_b[int'(w_idx)*WIDTH +: WIDTH];
                  r_id    <= w_idx;
                  r_last  <= w_idx;
                  r_cnt   <= '0;
                  r_state <= EVAL;
               end
            end
            EVAL: begin
               if (r_cnt == CNT_LAST) begin
                  rsp_sum   <= adder_sum;
                  rsp_id    <= r_id;
                  rsp_valid <= 1'b1;
                  r_state   <= RESP;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  r_state   <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef ERR_MONITOR_EN
   logic [WIDTH:0]   w_ex;
   logic [WIDTH:0]   w_ae;
   logic             w_cap;
   logic [SAE_W:0]   w_sae_sum;
   logic [CNT_W-1:0] r_err_cnt;
   logic [SAE_W-1:0] r_err_sae;
   logic [WIDTH:0]   r_err_max;

   assign w_ex      = {1'b0, r_a} + {1'b0, r_b};
   assign w_ae      = (adder_sum >= w_ex) ? (adder_sum - w_ex) : (w_ex - adder_sum);
   assign w_cap     = (r_state == EVAL) && (r_cnt == CNT_LAST);
   assign w_sae_sum = {1'b0, r_err_sae} + (SAE_W+1)'(w_ae);

   // Accumulate error statistics at each sum capture; clear wins over update
   always_ff @(posedge Clk) begin
      if (Rst || err_clr) begin
         r_err_cnt <= '0;
         r_err_sae <= '0;
         r_err_max <= '0;
      end else if (w_cap) begin
         if (w_ae != '0) r_err_cnt <= r_err_cnt + 1'b1;
         r_err_sae <= w_sae_sum[SAE_W] ? '1 : w_sae_sum[SAE_W-1:0];
         if (w_ae > r_err_max) r_err_max <= w_ae;
      end
   end

   assign err_cnt    = r_err_cnt;
   assign err_sae    = r_err_sae;
   assign err_max_ae = r_err_max;
`endif

endmodule

// File: tb/tb_approx_add_arbiter.sv
// Bench for approx_add_arbiter: directed scenarios plus a randomized run,
// all checked each cycle against a transaction-timing reference model.
module tb_approx_add_arbiter;
   localparam int NREQ = 4;
   localparam int W    = 32;
   localparam int S    = 4;
   localparam int IDW  = 2;

   logic                 Clk;
   logic                 Rst;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*W-1:0]    req_a;
   logic [NREQ*W-1:0]    req_b;
   logic [W-1:0]         adder_a;
   logic [W-1:0]         adder_b;
   logic [W:0]           adder_sum;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [IDW-1:0]       rsp_id;
   logic [W:0]           rsp_sum;
   logic [1:0]           dbg_state;
`ifdef ERR_MONITOR_EN
   logic                 err_clr;
   logic [31:0]          err_cnt;
   logic [47:0]          err_sae;
   logic [W:0]           err_max_ae;
`endif

   // Environment adder: exact sum minus a programmable bias
   logic [W:0] bias;
   assign adder_sum = ({1'b0, adder_a} + {1'b0, adder_b}) - bias;

   approx_add_arbiter #(
      .NREQ(NREQ), .WIDTH(W), .SETTLE_CYC(S), .IDW(IDW)
   ) dut (
      .Clk(Clk), .Rst(Rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .adder_a(adder_a), .adder_b(adder_b), .adder_sum(adder_sum),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_sum(rsp_sum),
`ifdef ERR_MONITOR_EN
      .err_clr(err_clr), .err_cnt(err_cnt), .err_sae(err_sae), .err_max_ae(err_max_ae),
`endif
      .dbg_state(dbg_state)
   );

   // Clock
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   // Requester side
   logic [NREQ-1:0] v;
   logic [W-1:0]    a [NREQ];
   logic [W-1:0]    b [NREQ];
   bit              auto_refill;
   logic            m_rst;
   logic            m_rr;

   // Reference model (transaction level)
   int         cyc;
   bit         m_known;
   bit         outst;
   int         rsp_from;
   int         ok_cyc;
   int         m_last;
   int         m_id;
   logic [W:0] m_sum;
   logic [W-1:0] m_op_a;
   logic [W-1:0] m_op_b;

   // Observations of the DUT for directed scenario checks
   int         obs_gnt_q[$];
   logic [W:0] obs_sum_q[$];
   int         obs_id_q[$];
   int         obs_t_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_obs();
      obs_gnt_q.delete();
      obs_sum_q.delete();
      obs_id_q.delete();
      obs_t_q.delete();
   endtask

   // One clock cycle: drive, check against the model, advance the model
   task automatic step();
      bit              grant;
      int              g;
      logic [NREQ-1:0] exp_rdy;
      bit              exp_v;
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]       = v[i];
         req_a[i*W +: W]    = a[i];
         req_b[i*W +: W]    = b[i];
      end
      Rst       = m_rst;
      rsp_ready = m_rr;
      #1;
      grant   = 0;
      g       = 0;
      exp_rdy = '0;
      exp_v   = 0;
      if (!m_rst && !outst && cyc >= ok_cyc) begin
         for (int k = 1; k <= NREQ; k++) begin
            int p;
            p = (m_last + k) % NREQ;
            if (v[p] && !grant) begin
               grant = 1;
               g     = p;
            end
         end
         if (grant) exp_rdy[g] = 1'b1;
      end
      chk("req_ready", req_ready, exp_rdy);
      if (m_known) begin
         chk("adder_a", adder_a, m_op_a);
         chk("adder_b", adder_b, m_op_b);
         exp_v = outst && (cyc >= rsp_from);
         chk("rsp_valid", rsp_valid, exp_v);
         if (exp_v) begin
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_sum", rsp_sum, m_sum);
         end
      end
      for (int k = 0; k < NREQ; k++)
         if (req_ready[k] === 1'b1) obs_gnt_q.push_back(k);
      if (!m_rst && rsp_valid === 1'b1 && m_rr) begin
         obs_sum_q.push_back(rsp_sum);
         obs_id_q.push_back(int'(rsp_id));
         obs_t_q.push_back(cyc);
      end
      if (m_rst) begin
         outst   = 0;
         m_last  = NREQ - 1;
         ok_cyc  = cyc + 1;
         m_op_a  = '0;
         m_op_b  = '0;
         m_known = 1;
      end else if (grant) begin
         outst    = 1;
         rsp_from = cyc + S + 1;
         m_last   = g;
         m_id     = g;
         m_op_a   = a[g];
         m_op_b   = b[g];
         m_sum    = ({1'b0, a[g]} + {1'b0, b[g]}) - bias;
         if (!auto_refill) v[g] = 1'b0;
      end else if (exp_v && m_rr) begin
         outst  = 0;
         ok_cyc = cyc + 1;
      end
      @(negedge Clk);
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      v = '0;
      for (int i = 0; i < NREQ; i++) begin a[i] = '0; b[i] = '0; end
      auto_refill = 0;
      m_rst = 1; m_rr = 1; bias = '0;
      cyc = 0; m_known = 0; outst = 0; rsp_from = 0; ok_cyc = 0;
      m_last = NREQ - 1; m_id = 0; m_sum = '0; m_op_a = '0; m_op_b = '0;
      Rst = 1; rsp_ready = 1; req_valid = '0; req_a = '0; req_b = '0;
`ifdef ERR_MONITOR_EN
      err_clr = 0;
`endif
      @(negedge Clk);

      // Reset: req_ready must stay low under Rst even with every request up
      v = '1;
      run(3);
      m_rst = 0;
      v = '0;
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_id", rsp_id, '0);
      chk("rst_rsp_sum", rsp_sum, '0);
      chk("rst_adder_a", adder_a, '0);
      chk("rst_adder_b", adder_b, '0);
      chk("rst_state", dbg_state, 2'd0);

      // Single request 5+7 from requester 0
      clear_obs();
      v[0] = 1; a[0] = 32'd5; b[0] = 32'd7;
      run(S + 4);
      chk("t1_grants", obs_gnt_q.size(), 1);
      if (obs_gnt_q.size() > 0) chk("t1_gnt_id", obs_gnt_q[0], 0);
      chk("t1_rsps", obs_sum_q.size(), 1);
      if (obs_sum_q.size() > 0) begin
         chk("t1_sum", obs_sum_q[0], 33'd12);
         chk("t1_id", obs_id_q[0], 0);
      end

      // All requesters continuously valid: fair order and peak throughput
      m_rst = 1; run(1); m_rst = 0;
      clear_obs();
      auto_refill = 1;
      for (int i = 0; i < NREQ; i++) begin v[i] = 1; a[i] = W'(i); b[i] = 32'd100; end
      run(5 * (S + 2));
      auto_refill = 0;
      v = '0;
      run(S + 3);
      chk("t2_grants", obs_gnt_q.size(), 5);
      for (int i = 0; i < 5 && i < obs_gnt_q.size(); i++)
         chk("t2_order", obs_gnt_q[i], i % NREQ);
      for (int i = 0; i < 4 && i < obs_sum_q.size(); i++)
         chk("t2_sum", obs_sum_q[i], 33'd100 + 33'(i));
      for (int i = 1; i < 4 && i < obs_t_q.size(); i++)
         chk("t2_period", obs_t_q[i] - obs_t_q[i-1], S + 2);

      // Carry-out captured; requester 3 raises and drops valid while busy
      clear_obs();
      v[2] = 1; a[2] = 32'hFFFF_FFFF; b[2] = 32'd1;
      run(2);
      v[3] = 1; a[3] = 32'd9; b[3] = 32'd9;
      run(1);
      v[3] = 0;
      run(S + 2);
      chk("t3_rsps", obs_sum_q.size(), 1);
      if (obs_sum_q.size() > 0) chk("t3_carry", obs_sum_q[0], 33'h1_0000_0000);
      chk("t3_grants", obs_gnt_q.size(), 1);

      // Response stall: nothing granted while rsp_ready is low
      clear_obs();
      v[1] = 1; a[1] = 32'h1234_5678; b[1] = 32'h0101_0101;
      run(1);
      v = '1;
      for (int i = 0; i < NREQ; i++) begin a[i] = $urandom; b[i] = $urandom; end
      m_rr = 0;
      run(S + 11);
      chk("t4_stall_grants", obs_gnt_q.size(), 1);
      m_rr = 1;
      run(3);
      v = '0;
      run(S + 3);
      chk("t4_first", obs_gnt_q.size() > 0 ? obs_gnt_q[0] : -1, 1);
      chk("t4_next", obs_gnt_q.size() > 1 ? obs_gnt_q[1] : -1, 2);

      // Reset during EVAL discards the transaction and restarts at requester 0
      v[2] = 1; a[2] = 32'd40; b[2] = 32'd2;
      run(3);
      m_rst = 1; run(1); m_rst = 0;
      clear_obs();
      v = '1;
      run(1);
      v = '0;
      run(S);
      chk("t5_grant0", obs_gnt_q.size() > 0 ? obs_gnt_q[0] : -1, 0);
      chk("t5_no_rsp", obs_sum_q.size(), 0);
      run(3);

      // Randomized traffic with random drops, back-pressure and resets
      for (int n = 0; n < 800; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!v[i] && $urandom_range(2, 0) == 0) begin
               v[i] = 1; a[i] = $urandom; b[i] = $urandom;
            end else if (v[i] && $urandom_range(11, 0) == 0) begin
               v[i] = 0;
            end
         end
         m_rr  = ($urandom_range(3, 0) != 0);
         m_rst = ($urandom_range(199, 0) == 0);
         step();
      end
      m_rst = 0; m_rr = 1; v = '0;
      run(S + 4);

`ifdef ERR_MONITOR_EN
      // Error monitor with an adder that is always 8 low
      m_rst = 1; run(1); m_rst = 0;
      bias = 33'd8;
      for (int k = 0; k < 3; k++) begin
         v[k] = 1; a[k] = 32'd100 * 32'(k + 1); b[k] = 32'(k);
         run(S + 3);
      end
      chk("err_cnt", err_cnt, 32'd3);
      chk("err_sae", err_sae, 48'd24);
      chk("err_max_ae", err_max_ae, 33'd8);
      err_clr = 1;
      run(1);
      err_clr = 0;
      chk("clr_cnt", err_cnt, '0);
      chk("clr_sae", err_sae, '0);
      chk("clr_max", err_max_ae, '0);
      bias = '0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
